// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage types: physical tag, free-list pointer and the reset mapping size.
// SUPER (lanes per cycle) and PHYS_SZ (physical registers, power of two) may be overridden by define.
`ifndef SUPER
`define SUPER 2
`endif
`ifndef PHYS_SZ
`define PHYS_SZ 64
`endif

package phys_free_list_pkg;
  localparam int unsigned SUPER   = `SUPER;
  localparam int unsigned PHYS_SZ = `PHYS_SZ;
  localparam int unsigned ARCH_SZ = 32;
  localparam int unsigned PTAG_W  = $clog2(PHYS_SZ);
  localparam int unsigned PTR_W   = PTAG_W + 1;
  localparam int unsigned CNT_W   = $clog2(SUPER + 1);
  localparam int unsigned FREE_SZ = PHYS_SZ - ARCH_SZ;

  typedef logic [PTAG_W-1:0] ptag_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;
endpackage

// File: rtl/phys_free_list_lane_compact.sv
// Lane compaction: per-lane offset among asserted lanes (ascending order) plus total popcount.
module lane_compact
  import phys_free_list_pkg::*;
(
  input  logic [SUPER-1:0]            mask,
  output logic [SUPER-1:0][CNT_W-1:0] offs,
  output logic [CNT_W-1:0]            cnt
);

  always_comb begin
    cnt  = '0;
    offs = '0;
    for (int i = 0; i < int'(SUPER); i++) begin
      offs[i] = cnt;
      cnt     = cnt + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags with one-cycle flush recovery via retire_head.
// Optional double-free detection is built when PFL_DOUBLE_FREE_CHECK_EN is defined.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SUPER-1:0]             alloc_req,
  output logic                         alloc_ready,
  output logic [SUPER-1:0][PTAG_W-1:0] alloc_tag,
  input  logic [SUPER-1:0]             free_en,
  input  logic [SUPER-1:0][PTAG_W-1:0] free_tag,
  input  logic [SUPER-1:0]             retire_alloc,
  input  logic                         flush,
  output logic [PTAG_W:0]              free_count,
  output logic                         dbl_free_err
);

  ptag_t                       entries [PHYS_SZ];
  fl_ptr_t                     head, retire_head, tail, flush_head;
  logic [SUPER-1:0]            free_ok;
  logic [SUPER-1:0][CNT_W-1:0] a_offs, f_offs, r_offs;
  logic [CNT_W-1:0]            a_cnt, f_cnt, r_cnt;

  lane_compact u_alloc  (.mask(alloc_req),    .offs(a_offs), .cnt(a_cnt));
  lane_compact u_free   (.mask(free_ok),      .offs(f_offs), .cnt(f_cnt));
  lane_compact u_retire (.mask(retire_alloc), .offs(r_offs), .cnt(r_cnt));

  assign free_count  = tail - head;
  assign alloc_ready = (free_count >= PTR_W'(a_cnt)) && !flush;
  // Commit in the flush cycle is older than the flush, so its retires count.
  assign flush_head  = retire_head + PTR_W'(r_cnt);

  always_comb begin
    alloc_tag = '0;
    for (int i = 0; i < int'(SUPER); i++)
      alloc_tag[i] = entries[PTAG_W'(head[PTAG_W-1:0] + PTAG_W'(a_offs[i]))];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      retire_head <= '0;
      tail        <= PTR_W'(FREE_SZ);
      for (int i = 0; i < int'(PHYS_SZ); i++)
        entries[i] <= (i < int'(FREE_SZ)) ? PTAG_W'(ARCH_SZ + i) : '0;
    end else begin
      if (flush)
        head <= flush_head;
      else if (alloc_ready)
        head <= head + PTR_W'(a_cnt);
      retire_head <= flush_head;
      tail        <= tail + PTR_W'(f_cnt);
      for (int i = 0; i < int'(SUPER); i++)
        if (free_ok[i])
          entries[PTAG_W'(tail[PTAG_W-1:0] + PTAG_W'(f_offs[i]))] <= free_tag[i];
    end
  end

`ifdef PFL_DOUBLE_FREE_CHECK_EN
  logic [PHYS_SZ-1:0] in_list;
  logic [SUPER-1:0]   dup;

  // Drop a lane whose tag is already listed or repeats a lower lane's tag.
  always_comb begin
    dup     = '0;
    free_ok = '0;
    for (int i = 0; i < int'(SUPER); i++) begin
      for (int j = 0; j < i; j++)
        if (free_en[j] && (free_tag[j] == free_tag[i]))
          dup[i] = 1'b1;
      free_ok[i] = free_en[i] && !dup[i] && !in_list[free_tag[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbl_free_err <= 1'b0;
      for (int i = 0; i < int'(PHYS_SZ); i++)
        in_list[i] <= (i >= int'(ARCH_SZ));
    end else begin
      if (flush) begin
        // Re-list every entry in the squashed window [flush_head, head).
        for (int i = 0; i < int'(PHYS_SZ); i++)
          if ({1'b0, PTAG_W'(PTAG_W'(i) - flush_head[PTAG_W-1:0])} < PTR_W'(head - flush_head))
            in_list[entries[i]] <= 1'b1;
      end else if (alloc_ready) begin
        for (int i = 0; i < int'(SUPER); i++)
          if (alloc_req[i])
            in_list[alloc_tag[i]] <= 1'b0;
      end
      for (int i = 0; i < int'(SUPER); i++)
        if (free_ok[i])
          in_list[free_tag[i]] <= 1'b1;
      if (|(free_en & ~free_ok))
        dbl_free_err <= 1'b1;
    end
  end
`else
  assign free_ok      = free_en;
  assign dbl_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed scoreboard bench for phys_free_list (SUPER=2, PHYS_SZ=64, ARCH_SZ=32).
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [SUPER-1:0]             alloc_req;
  logic                         alloc_ready;
  logic [SUPER-1:0][PTAG_W-1:0] alloc_tag;
  logic [SUPER-1:0]             free_en;
  logic [SUPER-1:0][PTAG_W-1:0] free_tag;
  logic [SUPER-1:0]             retire_alloc;
  logic                         flush;
  logic [PTAG_W:0]              free_count;
  logic                         dbl_free_err;

  int          vecs = 0;
  int          errs = 0;
  int unsigned exp_q[$];
  int unsigned exp;

  phys_free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .free_en(free_en), .free_tag(free_tag),
    .retire_alloc(retire_alloc), .flush(flush), .free_count(free_count),
    .dbl_free_err(dbl_free_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alloc_req = '0; free_en = '0; free_tag = '0; retire_alloc = '0; flush = 1'b0;
  endtask

  // Inputs change just after negedge; outputs are sampled #1 later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vecs++; if (free_count !== PTR_W'(32)) begin errs++; $display("FAIL reset_free_count: got %0d expected 32", free_count); end
    vecs++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    vecs++; if (dbl_free_err !== 1'b0) begin errs++; $display("FAIL reset_dbl_free_err: got %b expected 0", dbl_free_err); end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    alloc_req = 2'b11;
    exp_q.push_back(32); exp_q.push_back(33);
    #1;
    vecs++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL pair_ready: got %b expected 1", alloc_ready); end
    for (int l = 0; l < 2; l++) begin
      exp = exp_q.pop_front();
      vecs++; if (alloc_tag[l] !== PTAG_W'(exp)) begin errs++; $display("FAIL pair_tag lane%0d: got %0d expected %0d", l, alloc_tag[l], exp); end
    end
    tick(); idle(); #1;
    vecs++; if (free_count !== PTR_W'(30)) begin errs++; $display("FAIL pair_free_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_single_lane();
    do_reset();
    alloc_req = 2'b10;
    exp_q.push_back(32);
    #1;
    vecs++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL lane1_ready: got %b expected 1", alloc_ready); end
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[1] !== PTAG_W'(exp)) begin errs++; $display("FAIL lane1_tag: got %0d expected %0d", alloc_tag[1], exp); end
    tick();
    alloc_req = 2'b01;
    exp_q.push_back(33);
    #1;
    vecs++; if (free_count !== PTR_W'(31)) begin errs++; $display("FAIL lane1_free_count: got %0d expected 31", free_count); end
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[0] !== PTAG_W'(exp)) begin errs++; $display("FAIL lane0_after_single: got %0d expected %0d", alloc_tag[0], exp); end
    tick(); idle(); #1;
    vecs++; if (free_count !== PTR_W'(30)) begin errs++; $display("FAIL lane0_free_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_empty();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      alloc_req = 2'b11;
      exp_q.push_back(32 + 2 * k); exp_q.push_back(33 + 2 * k);
      #1;
      for (int l = 0; l < 2; l++) begin
        exp = exp_q.pop_front();
        vecs++; if (alloc_tag[l] !== PTAG_W'(exp)) begin errs++; $display("FAIL drain_tag lane%0d: got %0d expected %0d", l, alloc_tag[l], exp); end
      end
      tick();
    end
    alloc_req = 2'b01;
    exp_q.push_back(62);
    #1;
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[0] !== PTAG_W'(exp)) begin errs++; $display("FAIL drain_last: got %0d expected %0d", alloc_tag[0], exp); end
    tick(); idle(); #1;
    vecs++; if (free_count !== PTR_W'(1)) begin errs++; $display("FAIL one_left_count: got %0d expected 1", free_count); end
    alloc_req = 2'b11; #1;
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL one_left_pair_ready: got %b expected 0", alloc_ready); end
    tick(); idle(); #1;
    vecs++; if (free_count !== PTR_W'(1)) begin errs++; $display("FAIL no_partial_grant: got %0d expected 1", free_count); end
    alloc_req = 2'b01;
    exp_q.push_back(63);
    #1;
    vecs++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL one_left_ready: got %b expected 1", alloc_ready); end
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[0] !== PTAG_W'(exp)) begin errs++; $display("FAIL one_left_tag: got %0d expected %0d", alloc_tag[0], exp); end
    tick(); idle(); #1;
    vecs++; if (free_count !== PTR_W'(0)) begin errs++; $display("FAIL empty_count: got %0d expected 0", free_count); end
    alloc_req = 2'b01; #1;
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL empty_ready: got %b expected 0", alloc_ready); end
    alloc_req = 2'b00; #1;
    vecs++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL empty_zero_req_ready: got %b expected 1", alloc_ready); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 2'b11; tick(); tick();
    idle(); retire_alloc = 2'b11; tick();
    idle(); flush = 1'b1; alloc_req = 2'b01; #1;
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL flush_suppress: got %b expected 0", alloc_ready); end
    tick(); idle(); #1;
    vecs++; if (free_count !== PTR_W'(30)) begin errs++; $display("FAIL flush_free_count: got %0d expected 30", free_count); end
    alloc_req = 2'b01;
    exp_q.push_back(34);
    #1;
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[0] !== PTAG_W'(exp)) begin errs++; $display("FAIL flush_next_tag: got %0d expected %0d", alloc_tag[0], exp); end
    tick();
    // Retire in the same cycle as the flush.
    do_reset();
    alloc_req = 2'b11; tick(); tick();
    idle(); flush = 1'b1; retire_alloc = 2'b01; tick();
    idle(); #1;
    vecs++; if (free_count !== PTR_W'(31)) begin errs++; $display("FAIL flush_retire_count: got %0d expected 31", free_count); end
    alloc_req = 2'b11;
    exp_q.push_back(33); exp_q.push_back(34);
    #1;
    for (int l = 0; l < 2; l++) begin
      exp = exp_q.pop_front();
      vecs++; if (alloc_tag[l] !== PTAG_W'(exp)) begin errs++; $display("FAIL flush_retire_tag lane%0d: got %0d expected %0d", l, alloc_tag[l], exp); end
    end
    tick(); idle();
  endtask

  task automatic test_free_bypass();
    do_reset();
    alloc_req = 2'b11;
    for (int k = 0; k < 16; k++) tick();
    idle(); #1;
    vecs++; if (free_count !== PTR_W'(0)) begin errs++; $display("FAIL full_drain_count: got %0d expected 0", free_count); end
    free_en = 2'b11; free_tag[0] = PTAG_W'(5); free_tag[1] = PTAG_W'(9); alloc_req = 2'b01; #1;
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL same_cycle_free_ready: got %b expected 0", alloc_ready); end
    tick();
    idle(); alloc_req = 2'b01;
    exp_q.push_back(5);
    #1;
    vecs++; if (free_count !== PTR_W'(2)) begin errs++; $display("FAIL freed_count: got %0d expected 2", free_count); end
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[0] !== PTAG_W'(exp)) begin errs++; $display("FAIL freed_first: got %0d expected %0d", alloc_tag[0], exp); end
    tick();
    free_en = 2'b10; free_tag[1] = PTAG_W'(7);
    exp_q.push_back(9);
    #1;
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[0] !== PTAG_W'(exp)) begin errs++; $display("FAIL freed_second: got %0d expected %0d", alloc_tag[0], exp); end
    tick();
    idle(); alloc_req = 2'b01;
    exp_q.push_back(7);
    #1;
    exp = exp_q.pop_front();
    vecs++; if (alloc_tag[0] !== PTAG_W'(exp)) begin errs++; $display("FAIL freed_lane1_only: got %0d expected %0d", alloc_tag[0], exp); end
    tick(); idle();
  endtask

`ifdef PFL_DOUBLE_FREE_CHECK_EN
  task automatic test_double_free();
    do_reset();
    free_en = 2'b01; free_tag[0] = PTAG_W'(40); tick();
    idle(); #1;
    vecs++; if (dbl_free_err !== 1'b1) begin errs++; $display("FAIL dbl_free_flag: got %b expected 1", dbl_free_err); end
    vecs++; if (free_count !== PTR_W'(32)) begin errs++; $display("FAIL dbl_free_count: got %0d expected 32", free_count); end
    do_reset(); #1;
    vecs++; if (dbl_free_err !== 1'b0) begin errs++; $display("FAIL dbl_free_reset: got %b expected 0", dbl_free_err); end
    alloc_req = 2'b01; tick();
    idle(); free_en = 2'b11; free_tag[0] = PTAG_W'(32); free_tag[1] = PTAG_W'(32); tick();
    idle(); #1;
    vecs++; if (free_count !== PTR_W'(32)) begin errs++; $display("FAIL dup_lane_count: got %0d expected 32", free_count); end
    vecs++; if (dbl_free_err !== 1'b1) begin errs++; $display("FAIL dup_lane_flag: got %b expected 1", dbl_free_err); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_alloc_pair();
    test_single_lane();
    test_empty();
    test_flush();
    test_free_bypass();
`ifdef PFL_DOUBLE_FREE_CHECK_EN
    test_double_free();
`endif
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
